key_debounce_led: RTL and testbench

Parametrised multi-channel push-button conditioner for the board's active-low keys. Each channel synchronises its raw key, filters contact bounce with a hold-time counter, and emits a clean level, single-cycle press/release pulses, and an LED output. The LED either toggles on every press or follows the key. It sits between the key pins and the LED/user logic, replacing the direct key-to-LED connection.

---
 rtl/key_debounce_led.sv | 119 +++++++++++
 tb/tb_key_debounce_led.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/key_debounce_led.sv
// key_debounce_led: multi-channel conditioner for active-low push buttons.
// Each channel synchronises its raw key, accepts a new level only after it
// has been seen on every one of CNT_MAX consecutive cycles, and drives a
// clean pressed level, one-cycle press/release pulses and an LED.
// All outputs come straight from flops, so no path runs from key to an output.
module key_debounce_led #(
  parameter int N       = 4,       // number of independent channels (1..16)
  parameter int CNT_MAX = 240000,  // stable cycles required before acceptance (>= 2)
  parameter int MODE    = 0        // 0: LED toggles per press, 1: LED follows key
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_state,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] led
);

  // Counter only has to reach CNT_MAX-1, so $clog2(CNT_MAX) bits suffice.
  localparam int           CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Synchroniser and filter state, kept in raw (active-low) polarity.
  logic [N-1:0]  sync1_q;
  logic [N-1:0]  sync2_q;
  logic [N-1:0]  stable_q;
  logic [N-1:0]  stable_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  // Registered outputs, active-high.
  logic [N-1:0]  state_q;
  logic [N-1:0]  state_d;
  logic [N-1:0]  press_q;
  logic [N-1:0]  press_d;
  logic [N-1:0]  release_q;
  logic [N-1:0]  release_d;
  logic [N-1:0]  led_q;
  logic [N-1:0]  led_d;

  // Two-flop synchroniser; resets to the released level so no phantom press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
    end
  end

  // Hold-time filter: a mismatch must persist for CNT_MAX samples to be taken.
  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    led_d     = led_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          // Accept the new level; the pulse fires in the same cycle it lands.
          stable_d[i]  = sync2_q[i];
          press_d[i]   = ~sync2_q[i];
          release_d[i] = sync2_q[i];
          if (MODE == 0 && !sync2_q[i]) begin
            led_d[i] = ~led_q[i];
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
      // Returning to the stable level leaves cnt_d at zero, discarding the glitch.
    end
    // key_state is taken from the next stable value so it moves with the pulse.
    state_d = ~stable_d;
    if (MODE != 0) begin
      led_d = state_d;
    end
  end

  // Filter state and hold counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= '1;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Output registers; asynchronous reset forces every output low at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      led_q     <= led_d;
    end
  end

  assign key_state   = state_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign led         = led_q;

endmodule

// File: tb/tb_key_debounce_led.sv
// Directed bench for key_debounce_led: N=2, CNT_MAX=8, one instance per MODE
// sharing the same key stimulus.
module tb_key_debounce_led;

  localparam int N  = 2;
  localparam int CM = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] key = 2'b11;
  logic [1:0] st0, pr0, rl0, led0;
  logic [1:0] st1, pr1, rl1, led1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  key_debounce_led #(.N(N), .CNT_MAX(CM), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .key(key),
    .key_state(st0), .key_press(pr0), .key_release(rl0), .led(led0)
  );

  key_debounce_led #(.N(N), .CNT_MAX(CM), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .key(key),
    .key_state(st1), .key_press(pr1), .key_release(rl1), .led(led1)
  );

  typedef struct {
    logic [1:0] k;      // key value applied
    int         hold;   // cycles held
    logic [1:0] st;     // final key_state
    logic [1:0] led_t;  // final led, toggle instance
    logic [1:0] led_f;  // final led, follow instance
    int         p0, p1, r0, r1; // pulse-cycle counts per channel
    int         dual;   // cycles with both channels pulsing together
    int         lat;    // cycle of first key_state change, 0 = none
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] k, input int hold,
                              input logic [1:0] st, input logic [1:0] lt,
                              input logic [1:0] lf, input int p0, input int p1,
                              input int r0, input int r1, input int dual,
                              input int lat);
    vec_t v;
    v.k = k; v.hold = hold; v.st = st; v.led_t = lt; v.led_f = lf;
    v.p0 = p0; v.p1 = p1; v.r0 = r0; v.r1 = r1; v.dual = dual; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge: drives key, runs hold cycles, sampling at each negedge.
  task automatic apply(input vec_t v, input int idx);
    logic [1:0] st_start;
    int p0, p1, r0, r1, dual, lat;
    p0 = 0; p1 = 0; r0 = 0; r1 = 0; dual = 0; lat = 0;
    st_start = st0;
    key = v.k;
    for (int c = 1; c <= v.hold; c++) begin
      @(posedge clk);
      @(negedge clk);
      p0 += int'(pr0[0]);
      p1 += int'(pr0[1]);
      r0 += int'(rl0[0]);
      r1 += int'(rl0[1]);
      if (pr0 == 2'b11 || rl0 == 2'b11) dual++;
      if (lat == 0 && st0 != st_start) lat = c;
    end
    check($sformatf("v%0d key_state", idx), int'(st0), int'(v.st));
    check($sformatf("v%0d led_toggle", idx), int'(led0), int'(v.led_t));
    check($sformatf("v%0d led_follow", idx), int'(led1), int'(v.led_f));
    check($sformatf("v%0d press0", idx), p0, v.p0);
    check($sformatf("v%0d press1", idx), p1, v.p1);
    check($sformatf("v%0d release0", idx), r0, v.r0);
    check($sformatf("v%0d release1", idx), r1, v.r1);
    check($sformatf("v%0d same_cycle", idx), dual, v.dual);
    check($sformatf("v%0d latency", idx), lat, v.lat);
  endtask

  initial begin
    int lat;

    // Reset: all outputs low.
    #2 rst = 1'b1;
    #1;
    check("rst key_state", int'(st0), 0);
    check("rst press", int'(pr0), 0);
    check("rst release", int'(rl0), 0);
    check("rst led_toggle", int'(led0), 0);
    check("rst key_state_f", int'(st1), 0);
    check("rst led_follow", int'(led1), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // key, hold, st, led_t, led_f, p0, p1, r0, r1, dual, lat
    tbl.push_back(mk(2'b11, 50, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));  // idle
    tbl.push_back(mk(2'b10, 20, 2'b01, 2'b01, 2'b01, 1, 0, 0, 0, 0, 10)); // ch0 press
    tbl.push_back(mk(2'b11, 20, 2'b00, 2'b01, 2'b00, 0, 0, 1, 0, 0, 10)); // ch0 release
    tbl.push_back(mk(2'b10, 20, 2'b01, 2'b00, 2'b01, 1, 0, 0, 0, 0, 10)); // 2nd press
    tbl.push_back(mk(2'b11, 20, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 10)); // 2nd release
    tbl.push_back(mk(2'b00, 20, 2'b11, 2'b11, 2'b11, 1, 1, 0, 0, 1, 10)); // both press
    tbl.push_back(mk(2'b11, 20, 2'b00, 2'b11, 2'b00, 0, 0, 1, 1, 1, 10)); // both release
    tbl.push_back(mk(2'b10,  7, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0));  // 7-cycle low
    tbl.push_back(mk(2'b11, 20, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0));  // ...rejected
    tbl.push_back(mk(2'b10,  8, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0));  // 8-cycle low
    tbl.push_back(mk(2'b11, 20, 2'b00, 2'b10, 2'b00, 1, 0, 1, 0, 0, 2));  // ...accepted
    for (int j = 0; j < 10; j++) begin                                    // ch1 bounce
      tbl.push_back(mk((j % 2 == 0) ? 2'b01 : 2'b11, 3,
                       2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0));
    end
    tbl.push_back(mk(2'b01, 20, 2'b10, 2'b00, 2'b10, 0, 1, 0, 0, 0, 10)); // hold low
    tbl.push_back(mk(2'b11, 20, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 10)); // release

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset mid-count while key held, then pressed again after deassertion.
    apply(mk(2'b01, 20, 2'b10, 2'b10, 2'b10, 0, 1, 0, 0, 0, 10), 100);
    key = 2'b00;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("pre-rst key_state", int'(st0), 2);
    #2 rst = 1'b1;
    #1;
    check("async rst key_state", int'(st0), 0);
    check("async rst led_toggle", int'(led0), 0);
    check("async rst key_state_f", int'(st1), 0);
    check("async rst led_follow", int'(led1), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (lat == 0 && pr0 == 2'b11) lat = c;
    end
    check("post-rst press latency", lat, 10);
    check("post-rst key_state", int'(st0), 3);
    check("post-rst led_toggle", int'(led0), 3);
    check("post-rst led_follow", int'(led1), 3);
    apply(mk(2'b11, 20, 2'b00, 2'b11, 2'b00, 0, 0, 1, 1, 1, 10), 101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
